// File: rtl/serial_mag_compare_pkg.sv
// Shared definitions for the serial magnitude comparator: FSM state encoding,
// result-flag bit positions and a helper that packs the three flags.
package serial_mag_compare_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam int RES_GT = 0;
   localparam int RES_LT = 1;
   localparam int RES_EQ = 2;
   localparam int RES_W  = 3;

   function automatic logic [RES_W-1:0] pack_result(input logic gt, input logic lt, input logic eq);
      logic [RES_W-1:0] r;
      r         = 3'b000;
      r[RES_GT] = gt;
      r[RES_LT] = lt;
      r[RES_EQ] = eq;
      return r;
   endfunction

endpackage

// File: rtl/serial_mag_compare_comparator_2bit.sv
// Combinational 2-bit unsigned digit comparator, time-shared by the serial
// magnitude comparator.
module comparator_2bit (
   input  logic [1:0] i_a,
   input  logic [1:0] i_b,
   output logic       o_gt,
   output logic       o_lt,
   output logic       o_eq
);

   assign o_gt = (i_a > i_b);
   assign o_lt = (i_a < i_b);
   assign o_eq = (i_a == i_b);

endmodule

// File: rtl/serial_mag_compare.sv
// Serial magnitude comparator: walks two WIDTH-bit operands MSB digit first,
// two bits per cycle, and stops on the first unequal digit.
module serial_mag_compare
   import serial_mag_compare_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             a_gt_b,
   output logic             a_lt_b,
   output logic             a_eq_b
);

   localparam int D  = WIDTH / 2;
   localparam int CW = (D > 1) ? $clog2(D) : 1;

   state_t             r_state;
   state_t             w_next;
   logic [WIDTH-1:0]   r_sa;
   logic [WIDTH-1:0]   r_sb;
   logic [CW-1:0]      r_cnt;
   logic [RES_W-1:0]   r_flags;
   logic [RES_W-1:0]   w_flags;
   logic               r_busy;
   logic               r_done;
   logic               w_load;
   logic               w_shift;
   logic               w_gt;
   logic               w_lt;
   logic               w_eq;

   comparator_2bit u_cmp (
      .i_a  (r_sa[WIDTH-1 -: 2]),
      .i_b  (r_sb[WIDTH-1 -: 2]),
      .o_gt (w_gt),
      .o_lt (w_lt),
      .o_eq (w_eq)
   );

   // Next-state, datapath control and next result flags
   always_comb begin
      w_next  = r_state;
      w_load  = 1'b0;
      w_shift = 1'b0;
      w_flags = r_flags;
      case (r_state)
         S_IDLE, S_DONE: begin
            if (start) begin
               w_next = S_RUN;
               w_load = 1'b1;
            end else begin
               w_next = S_IDLE;
            end
         end
         S_RUN: begin
            if (!w_eq) begin
               w_next  = S_DONE;
               w_flags = pack_result(w_gt, w_lt, 1'b0);
            end else if (r_cnt == {CW{1'b0}}) begin
               w_next  = S_DONE;
               w_flags = pack_result(1'b0, 1'b0, 1'b1);
            end else begin
               w_next  = S_RUN;
               w_shift = 1'b1;
            end
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   // State, operand shifters, digit counter and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_sa    <= {WIDTH{1'b0}};
         r_sb    <= {WIDTH{1'b0}};
         r_cnt   <= {CW{1'b0}};
         r_flags <= {RES_W{1'b0}};
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_next;
         r_flags <= w_flags;
         r_busy  <= (w_next == S_RUN);
         r_done  <= (w_next == S_DONE);
         if (w_load) begin
            r_sa  <= a;
            r_sb  <= b;
            r_cnt <= CW'(D - 1);
         end else if (w_shift) begin
            r_sa  <= r_sa << 2'd2;
            r_sb  <= r_sb << 2'd2;
            r_cnt <= r_cnt - 1'b1;
         end
      end
   end

   assign busy   = r_busy;
   assign done   = r_done;
   assign a_gt_b = r_flags[RES_GT];
   assign a_lt_b = r_flags[RES_LT];
   assign a_eq_b = r_flags[RES_EQ];

endmodule

// File: tb/tb_serial_mag_compare.sv
// Self-checking bench for serial_mag_compare (WIDTH=16): directed scenarios plus
// randomized compares against an arithmetic reference model.
module tb_serial_mag_compare;

   localparam int W = 16;
   localparam int D = W / 2;

   logic         clk   = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [W-1:0] a     = '0;
   logic [W-1:0] b     = '0;
   logic         busy, done, a_gt_b, a_lt_b, a_eq_b;

   int           total = 0;
   int           bad   = 0;
   logic [2:0]   exp_flags = 3'b000;   // {gt, lt, eq}
   wire  [2:0]   obs_flags = {a_gt_b, a_lt_b, a_eq_b};

   serial_mag_compare #(.WIDTH(W)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .a      (a),
      .b      (b),
      .busy   (busy),
      .done   (done),
      .a_gt_b (a_gt_b),
      .a_lt_b (a_lt_b),
      .a_eq_b (a_eq_b)
   );

   always #5 clk = ~clk;

   task automatic chk1(input string tag, input logic obs, input logic exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chk3(input string tag, input logic [2:0] obs, input logic [2:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed={gt,lt,eq}=%b expected=%b", tag, obs, exp);
      end
   endtask

   // Reference: result by plain unsigned comparison; latency is the 1-based
   // index of the first differing 2-bit digit from the top, or D when equal.
   task automatic model(input logic [W-1:0] x, input logic [W-1:0] y,
                        output logic [2:0] f, output int lat);
      f   = {x > y, x < y, x == y};
      lat = D;
      for (int k = 0; k < D; k++) begin
         if ((x >> (W - 2 - 2 * k)) % 4 != (y >> (W - 2 - 2 * k)) % 4) begin
            lat = k + 1;
            break;
         end
      end
   endtask

   // Issues start with x/y, follows the run cycle by cycle and ends in the done cycle.
   task automatic run_cmp(input logic [W-1:0] x, input logic [W-1:0] y, input bit glitch);
      logic [2:0] f;
      int         lat;
      model(x, y, f, lat);
      start = 1'b1;
      a     = x;
      b     = y;
      @(posedge clk); #1;
      start = 1'b0;
      a     = W'($urandom);
      b     = W'($urandom);
      for (int n = 0; n < lat; n++) begin
         chk1("busy_run", busy, 1'b1);
         chk1("done_run", done, 1'b0);
         chk3("flags_hold_run", obs_flags, exp_flags);
         if (glitch && n == 1) begin
            start = 1'b1;
            a     = 16'hFFFF;
            b     = 16'h0000;
         end else begin
            start = 1'b0;
         end
         @(posedge clk); #1;
      end
      start = 1'b0;
      chk1("done_pulse", done, 1'b1);
      chk1("busy_in_done", busy, 1'b0);
      chk3("result", obs_flags, f);
      exp_flags = f;
   endtask

   task automatic idle_check();
      @(posedge clk); #1;
      chk1("done_idle", done, 1'b0);
      chk1("busy_idle", busy, 1'b0);
      chk3("flags_hold_idle", obs_flags, exp_flags);
   endtask

   initial begin
      logic [W-1:0] x, y;
      int           mode;

      #12;
      chk1("rst_busy", busy, 1'b0);
      chk1("rst_done", done, 1'b0);
      chk3("rst_flags", obs_flags, 3'b000);
      @(negedge clk);
      rst_n = 1'b1;
      idle_check();

      run_cmp(16'hA000, 16'h5000, 1'b0);
      idle_check();
      run_cmp(16'h0001, 16'h0002, 1'b0);
      idle_check();
      run_cmp(16'h1234, 16'h1234, 1'b0);
      idle_check();
      run_cmp(16'h00F0, 16'h00E0, 1'b1);
      idle_check();
      idle_check();

      // back-to-back: second start issued in the done cycle of the first
      run_cmp(16'h8000, 16'h8000, 1'b0);
      run_cmp(16'h0000, 16'h4000, 1'b0);
      idle_check();

      // reset in cycle 3 of an equal-operand compare
      start = 1'b1;
      a     = 16'h1234;
      b     = 16'h1234;
      @(posedge clk); #1;
      start = 1'b0;
      for (int n = 0; n < 3; n++) begin
         chk1("busy_pre_rst", busy, 1'b1);
         @(posedge clk); #1;
      end
      rst_n = 1'b0;
      #1;
      chk1("abort_busy", busy, 1'b0);
      chk1("abort_done", done, 1'b0);
      chk3("abort_flags", obs_flags, 3'b000);
      exp_flags = 3'b000;
      @(posedge clk); #1;
      chk1("held_rst_done", done, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int n = 0; n < 10; n++) idle_check();
      run_cmp(16'h1234, 16'h1234, 1'b0);
      idle_check();

      // randomized compares, biased toward long runs and single-digit differences
      for (int i = 0; i < 60; i++) begin
         x    = W'($urandom);
         mode = int'($urandom_range(0, 2));
         if (mode == 0) begin
            y = W'($urandom);
         end else if (mode == 1) begin
            y = x;
         end else begin
            y = x ^ (W'($urandom_range(1, 3)) << (2 * $urandom_range(0, D - 1)));
         end
         run_cmp(x, y, 1'($urandom_range(0, 1)));
         if ($urandom_range(0, 1) == 0) idle_check();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
